// File: rtl/alu_pkg.sv
// Shared alu opcode definitions and arbiter state encoding.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 4'b0000;
  localparam alu_op_t ALU_SUB = 4'b0001;
  localparam alu_op_t ALU_XOR = 4'b0100;
  localparam alu_op_t ALU_SLL = 4'b0101;
  localparam alu_op_t ALU_SRL = 4'b0110;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

  // Opcodes with bit 3 set are reserved encodings.
  function automatic logic alu_op_legal(alu_op_t op);
    return ~op[3];
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, alu and response signals of the shared-alu arbiter.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    ReqValid;
  logic [NUM_REQ-1:0]    ReqReady;
  logic [NUM_REQ*32-1:0] ReqSrcA;
  logic [NUM_REQ*32-1:0] ReqSrcB;
  logic [NUM_REQ*4-1:0]  ReqALUControl;
  logic [31:0]           SrcA;
  logic [31:0]           SrcB;
  logic [3:0]            ALUControl;
  logic [31:0]           ALUResult;
  logic                  Zero;
  logic                  RspValid;
  logic                  RspReady;
  logic [ID_W-1:0]       RspId;
  logic [31:0]           RspResult;
  logic                  RspZero;
  logic                  RspErr;

  // master = requesters plus the alu itself; slave = the arbiter
  modport master (
    output ReqValid, ReqSrcA, ReqSrcB, ReqALUControl, ALUResult, Zero, RspReady,
    input  ReqReady, SrcA, SrcB, ALUControl, RspValid, RspId, RspResult, RspZero, RspErr
  );
  modport slave (
    input  ReqValid, ReqSrcA, ReqSrcB, ReqALUControl, ALUResult, Zero, RspReady,
    output ReqReady, SrcA, SrcB, ALUControl, RspValid, RspId, RspResult, RspZero, RspErr
  );
endinterface

// File: rtl/alu_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first valid entry at or above ptr, with wrap-around.
module rr_priority_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);
  always_comb begin
    int j;
    j      = 0;
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    // Walk from farthest to nearest so the entry closest to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (valid[j]) begin
        any       = 1'b1;
        idx       = IDX_W'(j);
        onehot    = '0;
        onehot[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external alu among NUM_REQ requesters.
// Define ALU_ARB_OPCHECK_EN to answer opcodes with bit 3 set with an error, bypassing the alu.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);
  arb_state_t          state;
  logic [ID_W-1:0]     ptr;
  logic                gnt_any;
  logic [ID_W-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic [31:0]         sel_a, sel_b;
  alu_op_t             sel_op;
  logic [31:0]         src_a, src_b, rsp_result;
  alu_op_t             alu_ctl;
  logic                rsp_valid, rsp_zero;
  logic [ID_W-1:0]     rsp_id;

  rr_priority_picker #(.N(NUM_REQ), .IDX_W(ID_W)) u_pick (
    .valid  (bus.ReqValid),
    .ptr    (ptr),
    .any    (gnt_any),
    .idx    (gnt_idx),
    .onehot (gnt_oh)
  );

  assign sel_a  = bus.ReqSrcA[32*gnt_idx +: 32];
  assign sel_b  = bus.ReqSrcB[32*gnt_idx +: 32];
  assign sel_op = bus.ReqALUControl[4*gnt_idx +: 4];

  assign bus.ReqReady   = (state == IDLE && !reset) ? gnt_oh : '0;
  assign bus.SrcA       = src_a;
  assign bus.SrcB       = src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.RspValid   = rsp_valid;
  assign bus.RspId      = rsp_id;
  assign bus.RspResult  = rsp_result;
  assign bus.RspZero    = rsp_zero;

`ifdef ALU_ARB_OPCHECK_EN
  logic rsp_err;
  assign bus.RspErr = rsp_err;
`else
  assign bus.RspErr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      src_a      <= '0;
      src_b      <= '0;
      alu_ctl    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          rsp_id <= gnt_idx;
          ptr    <= ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
`ifdef ALU_ARB_OPCHECK_EN
          if (!alu_op_legal(sel_op)) begin
            // Illegal op answers directly; alu inputs keep the previous op.
            rsp_err    <= 1'b1;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            rsp_err <= 1'b0;
            src_a   <= sel_a;
            src_b   <= sel_b;
            alu_ctl <= sel_op;
            state   <= EXEC;
          end
`else
          src_a   <= sel_a;
          src_b   <= sel_b;
          alu_ctl <= sel_op;
          state   <= EXEC;
`endif
        end
        EXEC: begin
          rsp_result <= bus.ALUResult;
          rsp_zero   <= bus.Zero;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: if (bus.RspReady) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter with a behavioural alu and round-robin model.
module tb_alu_arbiter;
  import alu_pkg::*;
  localparam int NR = 2;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();
  alu_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      default: return a & b;
    endcase
  endfunction

  assign bus.ALUResult = alu_fn(bus.ALUControl, bus.SrcA, bus.SrcB);
  assign bus.Zero      = (bus.ALUResult == 32'd0);

  int          q_gnt[$];
  int          q_id[$];
  int          q_lat[$];
  logic [31:0] q_res[$];
  logic        q_zero[$];
  logic        q_err[$];

  task automatic clr_q();
    q_gnt.delete(); q_id.delete(); q_lat.delete(); q_res.delete(); q_zero.delete(); q_err.delete();
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.ReqSrcA[32*r +: 32]     = a;
    bus.ReqSrcB[32*r +: 32]     = b;
    bus.ReqALUControl[4*r +: 4] = op;
    bus.ReqValid[r]             = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.ReqValid = '0; bus.RspReady = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Records every grant cycle and every new response until nrsp responses are seen.
  task automatic drain(input int nrsp, input bit bp, input bit keep);
    int acc_cyc, got, g;
    bit hs;
    acc_cyc = -100; got = 0; hs = 1'b1;
    for (int cyc = 0; cyc < 400 && got < nrsp; cyc++) begin
      #1;
      g = -1;
      for (int i = 0; i < NR; i++) if (bus.ReqReady[i]) g = (g < 0) ? i : 99;
      if (g != -1) begin q_gnt.push_back(g); acc_cyc = cyc; end
      if (bus.RspValid && hs) begin
        q_id.push_back(int'(bus.RspId)); q_res.push_back(bus.RspResult);
        q_zero.push_back(bus.RspZero); q_err.push_back(bus.RspErr);
        q_lat.push_back(cyc - acc_cyc); got++;
      end
      if (bp) bus.RspReady = 1'($urandom_range(0, 1));
      hs = !bus.RspValid || bus.RspReady;
      @(posedge clk);
      if (g >= 0 && g < NR) begin #1 bus.ReqValid[g] = 1'b0; end
      @(negedge clk);
    end
    while (q_id.size() < nrsp) begin
      q_id.push_back(-1); q_res.push_back('x); q_zero.push_back(1'bx); q_err.push_back(1'bx); q_lat.push_back(-1);
    end
    while (q_gnt.size() < nrsp) q_gnt.push_back(-1);
    if (!keep) begin bus.RspReady = 1'b1; @(posedge clk); @(negedge clk); end
  endtask

  task automatic test_reset();
    logic [115:0] outs;
    bus.ReqValid = '1; bus.RspReady = 1'b1;
    bus.ReqSrcA = '1; bus.ReqSrcB = '1; bus.ReqALUControl = '0;
    repeat (2) @(negedge clk);
    #1;
    outs = {bus.SrcA, bus.SrcB, bus.ALUControl, bus.RspValid, bus.RspId, bus.RspResult, bus.RspZero, bus.RspErr, bus.ReqReady};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %0h want 0", outs); end
    bus.ReqValid = '0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (bus.RspValid !== 1'b0) begin n_bad++; $display("FAIL reset_idle_rspvalid: got %b want 0", bus.RspValid); end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, ALU_ADD, 32'd10, 32'd20);
    clr_q(); drain(1, 0, 0);
    n_cmp++; if (q_gnt.size() != 1 || q_gnt[0] != 0) begin n_bad++; $display("FAIL t1_ready_pulse: got %0d grants first %0d want 1 grant to 0", q_gnt.size(), q_gnt[0]); end
    n_cmp++; if (q_lat[0] != 2) begin n_bad++; $display("FAIL t1_latency: got %0d want 2", q_lat[0]); end
    n_cmp++; if (q_id[0] != 0) begin n_bad++; $display("FAIL t1_id: got %0d want 0", q_id[0]); end
    n_cmp++; if (q_res[0] !== 32'd30 || q_zero[0] !== 1'b0) begin n_bad++; $display("FAIL t1_result: got %0d z%b want 30 z0", q_res[0], q_zero[0]); end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_req(0, ALU_SUB, 32'd100, 32'd40);
    set_req(1, ALU_XOR, 32'hF0F0F0F0, 32'hFFFF0000);
    clr_q(); drain(2, 0, 0);
    n_cmp++; if (q_gnt.size() != 2 || q_gnt[0] != 0 || q_gnt[1] != 1) begin n_bad++; $display("FAIL t2_grant_order: got %0d grants %0d,%0d want 0,1", q_gnt.size(), q_gnt[0], q_gnt[1]); end
    n_cmp++; if (q_id[0] != 0 || q_res[0] !== 32'd60) begin n_bad++; $display("FAIL t2_rsp0: got id %0d res %0d want id 0 res 60", q_id[0], q_res[0]); end
    n_cmp++; if (q_id[1] != 1 || q_res[1] !== 32'h0F0FF0F0) begin n_bad++; $display("FAIL t2_rsp1: got id %0d res %h want id 1 res 0f0ff0f0", q_id[1], q_res[1]); end
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    set_req(1, ALU_ADD, 32'd2, 32'd2);
    clr_q(); drain(2, 0, 0);
    n_cmp++; if (q_gnt[0] != 0 || q_gnt[1] != 1) begin n_bad++; $display("FAIL t2_pointer_wrap: got %0d,%0d want 0,1", q_gnt[0], q_gnt[1]); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.RspReady = 1'b0;
    set_req(0, ALU_SLL, 32'd1, 32'd4);
    clr_q(); drain(1, 0, 1);
    n_cmp++; if (q_res[0] !== 32'd16 || q_lat[0] != 2) begin n_bad++; $display("FAIL t3_first: got res %0d lat %0d want 16 lat 2", q_res[0], q_lat[0]); end
    set_req(1, ALU_ADD, 32'd5, 32'd5);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (bus.RspValid !== 1'b1 || bus.RspResult !== 32'd16 || bus.RspId !== 2'd0) begin n_bad++; $display("FAIL t3_hold: cycle %0d got v%b res %0d id %0d want v1 res 16 id 0", i, bus.RspValid, bus.RspResult, bus.RspId); end
      n_cmp++; if (bus.ReqReady !== '0) begin n_bad++; $display("FAIL t3_no_ready: cycle %0d got %b want 0", i, bus.ReqReady); end
      @(negedge clk);
    end
    bus.RspReady = 1'b1;
    @(negedge clk);
    bus.ReqValid = '0; #1;
    n_cmp++; if (bus.RspValid !== 1'b0) begin n_bad++; $display("FAIL t3_release: got %b want 0", bus.RspValid); end
    @(negedge clk);
  endtask

  task automatic test_zero_flag();
    do_reset();
    set_req(0, ALU_SUB, 32'd100, 32'd100);
    clr_q(); drain(1, 0, 0);
    n_cmp++; if (q_res[0] !== 32'd0 || q_zero[0] !== 1'b1) begin n_bad++; $display("FAIL t4_zero_set: got res %0d z%b want 0 z1", q_res[0], q_zero[0]); end
    set_req(1, ALU_SRL, 32'd32, 32'd2);
    clr_q(); drain(1, 0, 0);
    n_cmp++; if (q_res[0] !== 32'd8 || q_zero[0] !== 1'b0 || q_id[0] != 1) begin n_bad++; $display("FAIL t4_zero_clr: got res %0d z%b id %0d want 8 z0 id 1", q_res[0], q_zero[0], q_id[0]); end
  endtask

  task automatic test_reset_midop();
    logic [115:0] outs;
    do_reset();
    set_req(0, ALU_ADD, 32'd3, 32'd4);
    @(posedge clk); #1 bus.ReqValid = '0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    outs = {bus.SrcA, bus.SrcB, bus.ALUControl, bus.RspValid, bus.RspId, bus.RspResult, bus.RspZero, bus.RspErr, bus.ReqReady};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL t5_exec_reset: got %0h want 0", outs); end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (bus.RspValid !== 1'b0) begin n_bad++; $display("FAIL t5_dropped: cycle %0d got %b want 0", i, bus.RspValid); end
    end
    @(negedge clk);
    bus.RspReady = 1'b0;
    set_req(0, ALU_ADD, 32'd3, 32'd4);
    @(posedge clk); #1 bus.ReqValid = '0;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (bus.RspValid !== 1'b1 || bus.RspResult !== 32'd7) begin n_bad++; $display("FAIL t5_resp_reached: got v%b res %0d want v1 res 7", bus.RspValid, bus.RspResult); end
    reset = 1'b1;
    @(negedge clk); #1;
    outs = {bus.SrcA, bus.SrcB, bus.ALUControl, bus.RspValid, bus.RspId, bus.RspResult, bus.RspZero, bus.RspErr, bus.ReqReady};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL t5_resp_reset: got %0h want 0", outs); end
    reset = 1'b0; bus.RspReady = 1'b1;
    @(negedge clk);
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    set_req(1, ALU_ADD, 32'd3, 32'd4);
    clr_q(); drain(2, 0, 0);
    n_cmp++; if (q_gnt[0] != 0 || q_res[0] !== 32'd3) begin n_bad++; $display("FAIL t5_ptr_reset: got grant %0d res %0d want 0 res 3", q_gnt[0], q_res[0]); end
  endtask

  task automatic test_opcheck();
    do_reset();
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    clr_q(); drain(1, 0, 0);
    set_req(1, 4'b1000, 32'd99, 32'd1);
    clr_q(); drain(1, 0, 1);
`ifdef ALU_ARB_OPCHECK_EN
    n_cmp++; if (q_lat[0] != 1 || q_err[0] !== 1'b1) begin n_bad++; $display("FAIL t6_illegal_rsp: got lat %0d err %b want lat 1 err 1", q_lat[0], q_err[0]); end
    n_cmp++; if (q_res[0] !== 32'd0 || q_zero[0] !== 1'b0) begin n_bad++; $display("FAIL t6_illegal_data: got res %0d z%b want 0 z0", q_res[0], q_zero[0]); end
    n_cmp++; if (bus.SrcA !== 32'd5 || bus.SrcB !== 32'd7 || bus.ALUControl !== ALU_ADD) begin n_bad++; $display("FAIL t6_alu_regs: got %0d %0d %0d want 5 7 0", bus.SrcA, bus.SrcB, bus.ALUControl); end
`else
    n_cmp++; if (q_lat[0] != 2 || q_err[0] !== 1'b0) begin n_bad++; $display("FAIL t6_forward_rsp: got lat %0d err %b want lat 2 err 0", q_lat[0], q_err[0]); end
    n_cmp++; if (q_res[0] !== 32'd1) begin n_bad++; $display("FAIL t6_forward_data: got res %0d want 1", q_res[0]); end
    n_cmp++; if (bus.SrcA !== 32'd99 || bus.SrcB !== 32'd1 || bus.ALUControl !== 4'b1000) begin n_bad++; $display("FAIL t6_alu_regs: got %0d %0d %0d want 99 1 8", bus.SrcA, bus.SrcB, bus.ALUControl); end
`endif
    bus.RspReady = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_random();
    alu_op_t     ops[5];
    alu_op_t     e_op[NR];
    logic [31:0] e_a[NR], e_b[NR];
    int          order[$];
    int          mptr, mask, last, i;
    logic [31:0] x_res;
    bit          legal;
    ops[0] = ALU_ADD; ops[1] = ALU_SUB; ops[2] = ALU_XOR; ops[3] = ALU_SLL; ops[4] = ALU_SRL;
    do_reset();
    mptr = 0;
    for (int rnd = 0; rnd < 40; rnd++) begin
      mask = $urandom_range(1, (1 << NR) - 1);
      order.delete();
      last = 0;
      for (int r = 0; r < NR; r++) if (mask[r]) begin
        e_op[r] = ops[$urandom_range(0, 4)];
`ifdef ALU_ARB_OPCHECK_EN
        if ($urandom_range(0, 5) == 0) e_op[r] = 4'b1000 | 4'($urandom_range(0, 7));
`endif
        e_a[r] = (rnd % 4 == 0) ? 32'd77 : $urandom;
        e_b[r] = (rnd % 4 == 0) ? 32'd77 : $urandom;
        set_req(r, e_op[r], e_a[r], e_b[r]);
      end
      // Requests all arrive together, so grants sweep upward from the model pointer.
      for (int k = 0; k < NR; k++) begin
        i = (mptr + k) % NR;
        if (mask[i]) begin order.push_back(i); last = i; end
      end
      mptr = (last + 1) % NR;
      clr_q(); drain(order.size(), 1, 0);
      n_cmp++; if (q_gnt.size() != order.size()) begin n_bad++; $display("FAIL rnd_grant_count: round %0d got %0d want %0d", rnd, q_gnt.size(), order.size()); end
      for (int j = 0; j < order.size(); j++) begin
        i = order[j];
`ifdef ALU_ARB_OPCHECK_EN
        legal = !e_op[i][3];
`else
        legal = 1'b1;
`endif
        x_res = legal ? alu_fn(e_op[i], e_a[i], e_b[i]) : 32'd0;
        n_cmp++; if (q_gnt[j] != i || q_id[j] != i) begin n_bad++; $display("FAIL rnd_order: round %0d slot %0d got grant %0d id %0d want %0d", rnd, j, q_gnt[j], q_id[j], i); end
        n_cmp++; if (q_res[j] !== x_res) begin n_bad++; $display("FAIL rnd_result: round %0d slot %0d got %h want %h", rnd, j, q_res[j], x_res); end
        n_cmp++; if (q_zero[j] !== (legal && x_res == 0) || q_err[j] !== !legal) begin n_bad++; $display("FAIL rnd_flags: round %0d slot %0d got z%b e%b want z%b e%b", rnd, j, q_zero[j], q_err[j], legal && x_res == 0, !legal); end
        n_cmp++; if (q_lat[j] != (legal ? 2 : 1)) begin n_bad++; $display("FAIL rnd_latency: round %0d slot %0d got %0d want %0d", rnd, j, q_lat[j], legal ? 2 : 1); end
      end
    end
  endtask

  initial begin
    bus.ReqValid = '0; bus.ReqSrcA = '0; bus.ReqSrcB = '0; bus.ReqALUControl = '0; bus.RspReady = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_zero_flag();
    test_reset_midop();
    test_opcheck();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
